// File: rtl/booth_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier_param
// Purpose  : Sequential radix-2 Booth multiplier with WIDTH-bit operands and
//            a per-operation signed/unsigned mode. One Booth step per clock;
//            WIDTH+1 clocks from accept to the done pulse.
// Ports    : clock        - rising-edge clock
//            reset        - synchronous, active-high reset
//            start        - request, sampled only in IDLE or DONE
//            is_signed    - 1 = two's-complement operands, 0 = unsigned
//            multiplicand - operand M (sampled with start)
//            multiplier   - operand Q (sampled with start)
//            product      - 2*WIDTH-bit result, held until next completion
//            busy         - high while an operation is running
//            done         - one-cycle pulse when product becomes valid
// Revision : 1.0 - initial parametrised release
// ============================================================================
module booth_multiplier_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // Operands carry one extra bit so unsigned values are treated as
    // non-negative two's-complement numbers; A carries one more bit so that
    // subtracting the extended M can never overflow.
    localparam int c_qw = WIDTH + 1;
    localparam int c_aw = WIDTH + 2;
    localparam int c_cw = $clog2(WIDTH + 2);

    localparam logic [c_cw-1:0] c_count_init = c_cw'(WIDTH + 1);
    localparam logic [c_cw-1:0] c_count_last = c_cw'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_aw-1:0]      r_a;
    logic [c_qw-1:0]      r_q;
    logic                 r_qm1;
    logic [c_qw-1:0]      r_m;
    logic [c_cw-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [c_qw-1:0]      w_m_ext;
    logic [c_qw-1:0]      w_q_ext;
    logic [c_aw-1:0]      w_m_acc;
    logic [c_aw-1:0]      w_a_sum;
    logic [c_aw+c_qw:0]   w_shift;
    logic [c_aw-1:0]      w_a_next;
    logic [c_qw-1:0]      w_q_next;
    logic                 w_qm1_next;

    // The signedness is folded into the extension bit at accept time, so the
    // mode does not need to be held separately during RUN.
    assign w_m_ext = is_signed ? {multiplicand[WIDTH-1], multiplicand}
                               : {1'b0, multiplicand};
    assign w_q_ext = is_signed ? {multiplier[WIDTH-1], multiplier}
                               : {1'b0, multiplier};

    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_last   = (r_count == c_count_last);

    assign w_m_acc = {r_m[c_qw-1], r_m};

    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_a_sum = r_a + w_m_acc;
            2'b10:   w_a_sum = r_a - w_m_acc;
            default: w_a_sum = r_a;
        endcase
    end

    // Arithmetic shift right of {A, Q, q_m1}: prepend the A sign bit and
    // drop the old q_m1; the bit leaving Q becomes the new q_m1.
    assign w_shift    = {w_a_sum[c_aw-1], w_a_sum, r_q};
    assign w_a_next   = w_shift[c_aw+c_qw:c_qw+1];
    assign w_q_next   = w_shift[c_qw:1];
    assign w_qm1_next = w_shift[0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle,
            c_st_done: w_state_next = start ? c_st_run : c_st_idle;
            c_st_run:  w_state_next = w_last ? c_st_done : c_st_run;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a     <= '0;
            r_q     <= w_q_ext;
            r_qm1   <= 1'b0;
            r_m     <= w_m_ext;
            r_count <= c_count_init;
        end else if (r_state == c_st_run) begin
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_qm1   <= w_qm1_next;
            r_count <= r_count - c_cw'(1);
            // Capture from the post-shift value so product is valid together
            // with done. Low 2*WIDTH bits of {A,Q} = all of Q plus A[W-2:0].
            if (w_last) begin
                r_product <= {w_a_next[WIDTH-2:0], w_q_next};
            end
        end
    end

    assign product = r_product;
    assign busy    = (r_state == c_st_run);
    assign done    = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_multiplier_param
// Purpose  : Self-checking bench for booth_multiplier_param (WIDTH=4 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [3:0]  multiplicand = '0;
    logic [3:0]  multiplier = '0;
    logic [7:0]  product;
    logic        busy;
    logic        done;

    logic        start8 = 1'b0;
    logic        is_signed8 = 1'b0;
    logic [7:0]  multiplicand8 = '0;
    logic [7:0]  multiplier8 = '0;
    logic [15:0] product8;
    logic        busy8;
    logic        done8;

    int checks = 0;
    int failures = 0;

    logic [7:0]  sb4[$];
    logic [15:0] sb8[$];

    always #5 clock = ~clock;

    booth_multiplier_param #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product(product), .busy(busy), .done(done)
    );

    booth_multiplier_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(is_signed8),
        .multiplicand(multiplicand8), .multiplier(multiplier8),
        .product(product8), .busy(busy8), .done(done8)
    );

    typedef struct {
        logic       s;
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the accept edge; returns the number
    // of clocks to done and how many of those cycles had busy high.
    task automatic wait_done4(output int j, output int bc);
        j = 0; bc = 0;
        while (!done && j < 50) begin
            if (busy) bc++;
            @(negedge clock);
            j++;
        end
    endtask

    task automatic check_result4(input string name);
        logic [7:0] exp;
        exp = (sb4.size() > 0) ? sb4.pop_front() : 8'hxx;
        check(name, {24'd0, product}, {24'd0, exp});
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic drive4(input logic s, input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
        start = 1'b1; is_signed = s; multiplicand = m; multiplier = q;
        sb4.push_back(exp);
    endtask

    task automatic run_op4(input string name, input logic s, input logic [3:0] m,
                           input logic [3:0] q, input logic [7:0] exp);
        int j, bc;
        @(negedge clock);
        drive4(s, m, q, exp);
        @(negedge clock);
        start = 1'b0;
        wait_done4(j, bc);
        check({name, "_latency"}, j, 5);
        check({name, "_busy_cycles"}, bc, 5);
        check_result4(name);
        @(negedge clock);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_op8(input string name, input logic s, input logic [7:0] m,
                           input logic [7:0] q, input logic [15:0] exp);
        int j;
        logic [15:0] e;
        @(negedge clock);
        start8 = 1'b1; is_signed8 = s; multiplicand8 = m; multiplier8 = q;
        sb8.push_back(exp);
        @(negedge clock);
        start8 = 1'b0;
        j = 0;
        while (!done8 && j < 50) begin
            @(negedge clock);
            j++;
        end
        check({name, "_latency"}, j, 9);
        e = (sb8.size() > 0) ? sb8.pop_front() : 16'hxxxx;
        check(name, {16'd0, product8}, {16'd0, e});
    endtask

    initial begin
        int j, bc, seen;
        logic       rs;
        logic [3:0] rm, rq;
        logic signed [7:0] sm, sq;
        logic [7:0] rexp;

        vecs[0]  = '{1'b1, 4'hD, 4'h7, 8'hEB};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[2]  = '{1'b1, 4'hF, 4'hF, 8'h01};
        vecs[3]  = '{1'b1, 4'h8, 4'h8, 8'h40};
        vecs[4]  = '{1'b1, 4'h0, 4'h9, 8'h00};
        vecs[5]  = '{1'b1, 4'h1, 4'hB, 8'hFB};
        vecs[6]  = '{1'b0, 4'h5, 4'h3, 8'h0F};
        vecs[7]  = '{1'b0, 4'h8, 4'h7, 8'h38};
        vecs[8]  = '{1'b1, 4'h7, 4'h7, 8'h31};
        vecs[9]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
        vecs[10] = '{1'b0, 4'hC, 4'hA, 8'h78};
        vecs[11] = '{1'b1, 4'hC, 4'hA, 8'h18};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {24'd0, product}, 32'd0);
        check("rst_product8", {16'd0, product8}, 32'd0);

        // Start asserted together with reset must be ignored
        start = 1'b1; multiplicand = 4'h3; multiplier = 4'h3;
        @(negedge clock);
        check("rst_over_start", {31'd0, busy}, 32'd0);
        start = 1'b0;
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_op4($sformatf("vec%0d", i), vecs[i].s, vecs[i].m, vecs[i].q, vecs[i].exp);
        end

        // Random operands against a reference product
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            rm = 4'($urandom_range(0, 15));
            rq = 4'($urandom_range(0, 15));
            if (rs) begin
                sm = 8'(signed'(rm));
                sq = 8'(signed'(rq));
                rexp = 8'(sm * sq);
            end else begin
                rexp = 8'({4'd0, rm} * {4'd0, rq});
            end
            run_op4($sformatf("rnd%0d", i), rs, rm, rq, rexp);
        end

        // Mid-RUN start and operand changes are ignored; then back-to-back
        @(negedge clock);
        drive4(1'b1, 4'hD, 4'h7, 8'hEB);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; is_signed = 1'b0; multiplicand = 4'hF; multiplier = 4'hF;
        @(negedge clock);
        start = 1'b0;
        j = 2; bc = 2;
        while (!done && j < 50) begin
            if (busy) bc++;
            @(negedge clock);
            j++;
        end
        check("midrun_latency", j, 5);
        check("midrun_busy_cycles", bc, 5);
        check_result4("midrun_product");
        // Accept a new operation during the DONE cycle
        drive4(1'b0, 4'h5, 4'h3, 8'h0F);
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy_next", {31'd0, busy}, 32'd1);
        check("b2b_done_next", {31'd0, done}, 32'd0);
        wait_done4(j, bc);
        check("b2b_latency", j, 5);
        check_result4("b2b_product");

        // Reset in the third RUN cycle aborts the operation
        @(negedge clock);
        start = 1'b1; is_signed = 1'b1; multiplicand = 4'h7; multiplier = 4'h7;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", {24'd0, product}, 32'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        run_op4("post_abort", 1'b0, 4'h5, 4'h3, 8'h0F);

        // WIDTH=8 instance
        run_op8("w8_min_x_max", 1'b1, 8'h80, 8'h7F, 16'hC080);
        run_op8("w8_uns_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_op8("w8_sgn_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
